adf4158_readback: RTL and testbench

Receives INT/FRAC readback from an ADF4158 synthesizer over its MUXOUT pin, the reverse direction of the `adf4158` configuration writer. On `start` it pulses TXDATA to raise the device interrupt, then clocks 37 readback bits out of the device on a generated serial clock and presents the captured INT and FRAC words with a one-cycle valid strobe. It sits beside `adf4158` in the synthesizer control path. The top level muxes `sclk` onto the device CLK pin while `sclk_oe` is high. Readback requires the device to be configured with MUXOUT = 4'b1111, READBACK_MUXOUT = 2'b10, INTERRUPT ≠ 2'b00 and BLEED_CURRENT = 2'b00.

---
 rtl/adf4158_readback_if.sv | 55 +++++
 rtl/adf4158_readback.sv | 195 +++++++++++++++++++
 tb/tb_adf4158_readback.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adf4158_readback_if.sv
// -----------------------------------------------------------------------------
// adf4158_readback_if
// Signal bundle between the ADF4158 readback engine and its surroundings
// (sequencer on one side, device pins on the other).
//
// Signals:
//   start    : request a readback (sampled only while the engine is idle)
//   busy     : engine is running a readback
//   txdata   : device TXDATA pin, pulsed high to raise the readback interrupt
//   sclk     : readback serial clock towards the device CLK pin
//   sclk_oe  : high while sclk should be muxed onto the device CLK pin
//   muxout   : device MUXOUT pin, asynchronous to clk
//   int_val  : captured 12-bit INT word
//   frac_val : captured 25-bit FRAC word
//   valid    : one-cycle strobe, int_val/frac_val updated in the same cycle
//
// Modports:
//   master : the readback engine (it masters the serial readback link)
//   slave  : the environment (sequencer + device pins)
// -----------------------------------------------------------------------------
interface adf4158_readback_if;
    logic        start;
    logic        busy;
    logic        txdata;
    logic        sclk;
    logic        sclk_oe;
    logic        muxout;
    logic [11:0] int_val;
    logic [24:0] frac_val;
    logic        valid;

    modport master (
        input  start,
        input  muxout,
        output busy,
        output txdata,
        output sclk,
        output sclk_oe,
        output int_val,
        output frac_val,
        output valid
    );

    modport slave (
        output start,
        output muxout,
        input  busy,
        input  txdata,
        input  sclk,
        input  sclk_oe,
        input  int_val,
        input  frac_val,
        input  valid
    );
endinterface

// File: rtl/adf4158_readback.sv
// -----------------------------------------------------------------------------
// adf4158_readback
// Reads the INT/FRAC words back from an ADF4158 over its MUXOUT pin.
// On start: pulse TXDATA high (raises the device interrupt), wait a settle
// time, then generate 37 sclk periods and shift MUXOUT in MSB first
// (INT[11..0] then FRAC[24..0]). The captured words are presented with a
// one-cycle valid strobe and held until the next capture.
//
// Parameters:
//   CLK_DIV  : clk cycles per sclk half-period (3..255 with the synchronizer,
//              1..255 without)
//   TX_PULSE : clk cycles txdata is held high (1..255)
//   SETTLE   : clk cycles from txdata fall to the first sclk rise (1..255)
//
// Ports:
//   clk   : block clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : adf4158_readback_if.master (start/busy/txdata/sclk/sclk_oe/
//           muxout/int_val/frac_val/valid)
//
// Configuration macro:
//   ADF4158_READBACK_SYNC_EN : when defined, muxout passes through a 2-flop
//   synchronizer before sampling; the effective pin sample point then lies
//   CLK_DIV-2 cycles after the sclk rise. When undefined, muxout is sampled
//   directly and must be synchronous to clk.
// -----------------------------------------------------------------------------
module adf4158_readback #(
    parameter int CLK_DIV  = 4,
    parameter int TX_PULSE = 4,
    parameter int SETTLE   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    adf4158_readback_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] TX_LAST    = 8'(TX_PULSE - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [5:0] LAST_BIT   = 6'd36;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;          // shared INTR / WAIT / sclk-phase timer
    logic [5:0]  bit_cnt_q, bit_cnt_d;  // index of the bit being clocked, 0..36
    logic [36:0] shreg_q, shreg_d;
    logic        sclk_q, sclk_d;
    logic        busy_q, busy_d;
    logic        txdata_q, txdata_d;
    logic        sclk_oe_q, sclk_oe_d;
    logic        valid_q, valid_d;
    logic [11:0] int_q, int_d;
    logic [24:0] frac_q, frac_d;
    logic        sample_s;

`ifdef ADF4158_READBACK_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer for the asynchronous MUXOUT pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.muxout;
            sync2_q <= sync1_q;
        end
    end

    assign sample_s = sync2_q;
`else
    assign sample_s = bus.muxout;
`endif

    // Next-state, counters, shift register and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        int_d     = int_q;
        frac_d    = frac_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_INTR;
                    cnt_d   = 8'd0;
                    shreg_d = 37'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INTR: begin
                if (cnt_q == TX_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    // sclk rises together with entry to SHIFT
                    state_d   = ST_SHIFT;
                    cnt_d     = 8'd0;
                    bit_cnt_d = 6'd0;
                    sclk_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (sclk_q) begin
                        // sclk falls: capture the bit the device put out after the rise
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[35:0], sample_s};
                    end else if (bit_cnt_q == LAST_BIT) begin
                        // Last bit already sampled; leave after its full low phase
                        // so sclk is 0 when sclk_oe drops.
                        state_d = ST_DONE;
                        int_d   = shreg_q[36:25];
                        frac_d  = shreg_q[24:0];
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so the registers track the state
        busy_d    = (state_d != ST_IDLE);
        txdata_d  = (state_d == ST_INTR);
        sclk_oe_d = (state_d == ST_SHIFT);
        valid_d   = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 6'd0;
            shreg_q   <= 37'd0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            txdata_q  <= 1'b0;
            sclk_oe_q <= 1'b0;
            valid_q   <= 1'b0;
            int_q     <= 12'd0;
            frac_q    <= 25'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            txdata_q  <= txdata_d;
            sclk_oe_q <= sclk_oe_d;
            valid_q   <= valid_d;
            int_q     <= int_d;
            frac_q    <= frac_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.txdata   = txdata_q;
    assign bus.sclk     = sclk_q;
    assign bus.sclk_oe  = sclk_oe_q;
    assign bus.valid    = valid_q;
    assign bus.int_val  = int_q;
    assign bus.frac_val = frac_q;

endmodule

// File: tb/tb_adf4158_readback.sv
// -----------------------------------------------------------------------------
// tb_adf4158_readback
// Directed, table-driven bench for adf4158_readback. A small device model
// shifts a 37-bit word out on MUXOUT, one bit after each sclk rise, MSB first;
// the interrupt (txdata rise) rewinds it to bit 36.
// -----------------------------------------------------------------------------
module tb_adf4158_readback;

    localparam int CLK_DIV  = 4;
    localparam int TX_PULSE = 4;
    localparam int SETTLE   = 8;
    localparam int LATENCY  = TX_PULSE + SETTLE + 74 * CLK_DIV + 1;  // 309

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    adf4158_readback_if ifc();

    adf4158_readback #(
        .CLK_DIV (CLK_DIV),
        .TX_PULSE(TX_PULSE),
        .SETTLE  (SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    logic [36:0] model_word = 37'd0;

    // Device model: rewind on interrupt, present next bit shortly after each sclk rise
    initial begin : dev_model
        int idx;
        idx = 36;
        ifc.muxout = 1'b0;
        forever begin
            @(posedge ifc.sclk or posedge ifc.txdata);
            if (ifc.txdata === 1'b1) begin
                idx = 36;
            end else begin
                #1;
                ifc.muxout = model_word[idx];
                if (idx > 0) idx--;
            end
        end
    end

`ifndef ADF4158_READBACK_SYNC_EN
    adf4158_readback_if ifc1();

    adf4158_readback #(
        .CLK_DIV (1),
        .TX_PULSE(TX_PULSE),
        .SETTLE  (SETTLE)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc1)
    );

    logic [36:0] model1_word = 37'd0;

    // Synchronous device model for the CLK_DIV = 1 instance
    initial begin : dev_model1
        int idx;
        idx = 36;
        ifc1.muxout = 1'b0;
        ifc1.start  = 1'b0;
        forever begin
            @(posedge ifc1.sclk or posedge ifc1.txdata);
            if (ifc1.txdata === 1'b1) begin
                idx = 36;
            end else begin
                #1;
                ifc1.muxout = model1_word[idx];
                if (idx > 0) idx--;
            end
        end
    end
`endif

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One readback: start at cycle 0, observe cycles 1..LATENCY+20 at negedge.
    // noise adds stray start pulses during SHIFT and in the DONE cycle.
    task automatic run_txn(input logic [36:0] word, input bit noise,
                           output int lat, output int tx_first, output int tx_len,
                           output int gap, output int pulses, output int bad,
                           output int vwidth);
        int  sclk_first;
        int  run;
        logic prev_sclk;
        logic exp_oe;
        model_word = word;
        lat = -1; tx_first = -1; tx_len = 0; sclk_first = -1;
        pulses = 0; bad = 0; vwidth = 0; run = 0; prev_sclk = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1;
        for (int c = 1; c <= LATENCY + 20; c++) begin
            @(negedge clk);
            ifc.start = (noise && (c == 60 || c == 61 || c == 200 || c == LATENCY)) ? 1'b1 : 1'b0;
            if (ifc.txdata === 1'b1) begin
                if (tx_first < 0) tx_first = c;
                tx_len++;
            end
            if (ifc.sclk !== prev_sclk) begin
                if (sclk_first >= 0 && run != CLK_DIV) bad++;
                run = 1;
                if (ifc.sclk === 1'b1) begin
                    pulses++;
                    if (sclk_first < 0) sclk_first = c;
                end
            end else begin
                run++;
            end
            exp_oe = (sclk_first >= 0) && (lat < 0) && (ifc.valid !== 1'b1);
            if (ifc.sclk_oe !== exp_oe) bad++;
            if (ifc.sclk_oe !== 1'b1 && ifc.sclk === 1'b1) bad++;
            if (ifc.busy !== ((c <= LATENCY) ? 1'b1 : 1'b0)) bad++;
            if (ifc.valid === 1'b1) begin
                vwidth++;
                if (lat < 0) begin
                    lat = c;
                    // last low phase plus the DONE cycle
                    if (run != CLK_DIV + 1) bad++;
                end
            end
            prev_sclk = ifc.sclk;
        end
        gap = sclk_first - (tx_first + tx_len);
    endtask

    typedef struct {
        logic [11:0] int_w;
        logic [24:0] frac_w;
        bit          noise;
        logic [11:0] exp_int;
        logic [24:0] exp_frac;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int lat, tx_first, tx_len, gap, pulses, bad, vwidth;
        int vt[3];
        int nv;
        int nvalid;
        logic prev;

        vecs[0] = '{int_w: 12'd265,  frac_w: 25'h1ABCDEF, noise: 1'b0, exp_int: 12'h109, exp_frac: 25'h1ABCDEF};
        vecs[1] = '{int_w: 12'hFFF,  frac_w: 25'h1FFFFFF, noise: 1'b0, exp_int: 12'hFFF, exp_frac: 25'h1FFFFFF};
        vecs[2] = '{int_w: 12'hAAA,  frac_w: 25'h0AAAAAA, noise: 1'b0, exp_int: 12'hAAA, exp_frac: 25'h0AAAAAA};
        vecs[3] = '{int_w: 12'h801,  frac_w: 25'h0000001, noise: 1'b0, exp_int: 12'h801, exp_frac: 25'h0000001};
        vecs[4] = '{int_w: 12'h000,  frac_w: 25'h0000000, noise: 1'b0, exp_int: 12'h000, exp_frac: 25'h0000000};
        vecs[5] = '{int_w: 12'h123,  frac_w: 25'h1555555, noise: 1'b1, exp_int: 12'h123, exp_frac: 25'h1555555};

        ifc.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",    64'(ifc.busy),     64'd0);
        check("reset_txdata",  64'(ifc.txdata),   64'd0);
        check("reset_sclk",    64'(ifc.sclk),     64'd0);
        check("reset_sclk_oe", 64'(ifc.sclk_oe),  64'd0);
        check("reset_valid",   64'(ifc.valid),    64'd0);
        check("reset_int",     64'(ifc.int_val),  64'd0);
        check("reset_frac",    64'(ifc.frac_val), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven readbacks with full timing checks
        for (int i = 0; i < 6; i++) begin
            run_txn({vecs[i].int_w, vecs[i].frac_w}, vecs[i].noise,
                    lat, tx_first, tx_len, gap, pulses, bad, vwidth);
            check($sformatf("v%0d_latency", i),   64'(lat),          64'(LATENCY));
            check($sformatf("v%0d_int", i),       64'(ifc.int_val),  64'(vecs[i].exp_int));
            check($sformatf("v%0d_frac", i),      64'(ifc.frac_val), 64'(vecs[i].exp_frac));
            check($sformatf("v%0d_tx_first", i),  64'(tx_first),     64'd1);
            check($sformatf("v%0d_tx_len", i),    64'(tx_len),       64'd4);
            check($sformatf("v%0d_settle", i),    64'(gap),          64'd8);
            check($sformatf("v%0d_pulses", i),    64'(pulses),       64'd37);
            check($sformatf("v%0d_shape", i),     64'(bad),          64'd0);
            check($sformatf("v%0d_vwidth", i),    64'(vwidth),       64'd1);
        end

        // start held high: back-to-back readbacks spaced latency + 1
        model_word = {12'hC35, 25'h0123456};
        nv = 0;
        @(negedge clk);
        ifc.start = 1'b1;
        for (int c = 1; c <= 3 * (LATENCY + 1) + 20 && nv < 3; c++) begin
            @(negedge clk);
            if (ifc.valid === 1'b1) begin
                vt[nv] = c;
                nv++;
                check("hold_int",  64'(ifc.int_val),  64'h0C35);
                check("hold_frac", 64'(ifc.frac_val), 64'h0123456);
            end
        end
        ifc.start = 1'b0;
        check("hold_count", 64'(nv), 64'd3);
        if (nv == 3) begin
            check("hold_first",   64'(vt[0]),         64'(LATENCY));
            check("hold_space_1", 64'(vt[1] - vt[0]), 64'(LATENCY + 1));
            check("hold_space_2", 64'(vt[2] - vt[1]), 64'(LATENCY + 1));
        end
        repeat (5) @(negedge clk);
        check("hold_idle_busy", 64'(ifc.busy), 64'd0);

        // Reset during bit 20 of SHIFT
        model_word = {12'h3C7, 25'h0FEDCBA};
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        pulses = 0;
        prev = 1'b0;
        for (int c = 0; c < 400 && pulses < 21; c++) begin
            @(negedge clk);
            if (ifc.sclk === 1'b1 && prev !== 1'b1) pulses++;
            prev = ifc.sclk;
        end
        check("rst_reached_bit20", 64'(pulses), 64'd21);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy",    64'(ifc.busy),     64'd0);
        check("rst_txdata",  64'(ifc.txdata),   64'd0);
        check("rst_sclk",    64'(ifc.sclk),     64'd0);
        check("rst_sclk_oe", 64'(ifc.sclk_oe),  64'd0);
        check("rst_valid",   64'(ifc.valid),    64'd0);
        check("rst_int",     64'(ifc.int_val),  64'd0);
        check("rst_frac",    64'(ifc.frac_val), 64'd0);
        nvalid = 0;
        for (int c = 0; c < 350; c++) begin
            @(negedge clk);
            if (ifc.valid === 1'b1) nvalid++;
        end
        check("rst_no_valid", 64'(nvalid), 64'd0);
        run_txn({12'h6E1, 25'h13579BD}, 1'b0, lat, tx_first, tx_len, gap, pulses, bad, vwidth);
        check("after_rst_latency", 64'(lat),          64'(LATENCY));
        check("after_rst_int",     64'(ifc.int_val),  64'h06E1);
        check("after_rst_frac",    64'(ifc.frac_val), 64'h13579BD);

`ifndef ADF4158_READBACK_SYNC_EN
        // CLK_DIV = 1 instance with a synchronous device model
        model1_word = {12'h5A3, 25'h0F0F0F3};
        lat = -1;
        @(negedge clk);
        ifc1.start = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            ifc1.start = 1'b0;
            if (ifc1.valid === 1'b1 && lat < 0) lat = c;
        end
        check("div1_latency", 64'(lat),           64'd87);
        check("div1_int",     64'(ifc1.int_val),  64'h05A3);
        check("div1_frac",    64'(ifc1.frac_val), 64'h0F0F0F3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
